// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, data-memory wait and timeout.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles/flush_events performance counters.
module hazard_stall_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_wr_en,
  input  logic        ex_mem_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_wr_en,
  output logic        if_id_wr_en,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_LOAD_STALL = 2'd1;
  localparam logic [1:0] S_MEM_WAIT   = 2'd2;
  localparam logic [1:0] S_ERROR      = 2'd3;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [7:0] r_wait_cnt;
  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_pc_wr_en;
  logic       w_if_id_wr_en;
  logic       w_bubble;
  logic       w_flush;
  logic       w_freeze;
  logic       w_timeout;

  assign w_load_use = ex_mem_rd && ex_reg_wr_en && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  // Once waiting, only mem_ready releases the freeze, whatever mem_req does.
  assign w_mem_stall = (r_state == S_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    w_pc_wr_en    = 1'b1;
    w_if_id_wr_en = 1'b1;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    w_freeze      = 1'b0;
    w_timeout     = 1'b0;
    w_next        = S_RUN;
    // The MEM_WAIT release cycle decodes like RUN so a pending branch or load-use is not lost.
    if (r_state == S_ERROR) begin
      w_pc_wr_en    = 1'b0;
      w_if_id_wr_en = 1'b0;
      w_freeze      = 1'b1;
      w_timeout     = 1'b1;
      w_next        = S_ERROR;
    end else if (w_mem_stall) begin
      w_pc_wr_en    = 1'b0;
      w_if_id_wr_en = 1'b0;
      w_freeze      = 1'b1;
      w_next        = ((r_state == S_MEM_WAIT) && (r_wait_cnt >= WAIT_LIMIT)) ? S_ERROR : S_MEM_WAIT;
    end else if (ex_branch_taken) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if ((r_state != S_LOAD_STALL) && w_load_use) begin
      w_pc_wr_en    = 1'b0;
      w_if_id_wr_en = 1'b0;
      w_bubble      = 1'b1;
      w_next        = S_LOAD_STALL;
    end
    if (rst) begin
      w_pc_wr_en    = 1'b1;
      w_if_id_wr_en = 1'b1;
      w_bubble      = 1'b0;
      w_flush       = 1'b0;
      w_freeze      = 1'b0;
      w_timeout     = 1'b0;
      w_next        = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state != S_MEM_WAIT) && w_mem_stall && (r_state != S_ERROR))
        r_wait_cnt <= 8'd1;
      else if ((r_state == S_MEM_WAIT) && w_mem_stall && (r_wait_cnt != '1))
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign pc_wr_en     = w_pc_wr_en;
  assign if_id_wr_en  = w_if_id_wr_en;
  assign id_ex_bubble = w_bubble;
  assign if_id_flush  = w_flush;
  assign pipe_freeze  = w_freeze;
  assign mem_timeout  = w_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!w_pc_wr_en && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush && (r_flush_events != '1))
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed vectors push expectations, a monitor checks them.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_reg_wr_en, ex_mem_rd, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_wr_en, if_id_wr_en, id_ex_bubble, if_id_flush, pipe_freeze, mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  hazard_stall_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_reg_wr_en(ex_reg_wr_en), .ex_mem_rd(ex_mem_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // Expected vector bit order: {pc_wr_en, if_id_wr_en, id_ex_bubble, if_id_flush, pipe_freeze, mem_timeout}
  localparam logic [5:0] E_RUN   = 6'b110000;
  localparam logic [5:0] E_LU    = 6'b001000;
  localparam logic [5:0] E_FLUSH = 6'b111100;
  localparam logic [5:0] E_FRZ   = 6'b000010;
  localparam logic [5:0] E_ERR   = 6'b000011;

  typedef struct {
    string       name;
    logic [5:0]  exp;
    bit          chk_cnt;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
  } item_t;

  item_t q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          stim_done = 1'b0;

  bit          nxt_chk = 1'b0;
  logic [31:0] nxt_stall, nxt_flush;

  function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic expect_counts(input logic [31:0] s, input logic [31:0] f);
    nxt_chk   = 1'b1;
    nxt_stall = cnt(s);
    nxt_flush = cnt(f);
  endtask

  task automatic step(input string nm, input logic r,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic ld, input logic br,
                      input logic mreq, input logic mrdy, input logic [5:0] exp);
    item_t it;
    @(posedge clk);
    #1;
    rst = r; id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2; id_rs2_used = u2;
    ex_rd_addr = rd; ex_reg_wr_en = wr; ex_mem_rd = ld; ex_branch_taken = br;
    mem_req = mreq; mem_ready = mrdy;
    it.name = nm; it.exp = exp; it.chk_cnt = nxt_chk;
    it.exp_stall = nxt_stall; it.exp_flush = nxt_flush;
    q.push_back(it);
    nxt_chk = 1'b0;
  endtask

  task automatic idle(input string nm, input logic r);
    step(nm, r, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      logic [5:0] got;
      it  = q.pop_front();
      got = {pc_wr_en, if_id_wr_en, id_ex_bubble, if_id_flush, pipe_freeze, mem_timeout};
      n_tests++;
      if (got !== it.exp) begin
        n_fail++;
        $display("FAIL %s: outputs got %b expected %b", it.name, got, it.exp);
      end
      if (it.chk_cnt) begin
        n_tests++;
        if (stall_cycles !== it.exp_stall || flush_events !== it.exp_flush) begin
          n_fail++;
          $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   it.name, stall_cycles, flush_events, it.exp_stall, it.exp_flush);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd_addr = '0; ex_reg_wr_en = 1'b0; ex_mem_rd = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;

    idle("reset0", 1'b1);
    idle("reset1", 1'b1);
    expect_counts(0, 0);
    idle("post_reset", 1'b0);

    // Load-use on rs1: exactly one bubble, even with the hazard still visible next cycle
    step("lu_rs1",       0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, E_LU);
    step("lu_rs1_held",  0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, E_RUN);
    idle("lu_after", 1'b0);

    step("lu_rd_zero",   0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, E_RUN);
    step("lu_rs1_unused",0, 5'd5, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, E_RUN);
    step("lu_no_wr",     0, 5'd5, 1, 5'd0, 0, 5'd5, 0, 1, 0, 0, 0, E_RUN);
    step("lu_rs2",       0, 5'd1, 1, 5'd9, 1, 5'd9, 1, 1, 0, 0, 0, E_LU);
    idle("lu_rs2_after", 1'b0);

    // Branch wins over load-use and must not enter LOAD_STALL
    step("br_over_lu",   0, 5'd7, 1, 5'd0, 0, 5'd7, 1, 1, 1, 0, 0, E_FLUSH);
    step("lu_after_br",  0, 5'd7, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0, E_LU);
    step("br_in_lstall", 0, 5'd7, 1, 5'd0, 0, 5'd7, 1, 1, 1, 0, 0, E_FLUSH);
    expect_counts(3, 2);
    idle("cnt_check1", 1'b0);

    // Memory wait: 3 frozen cycles then release
    idle("reset_mw", 1'b1);
    step("mw1",          0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
    step("mw2",          0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
    step("mw3",          0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
    step("mw_release",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, E_RUN);
    expect_counts(3, 0);
    idle("mw_after", 1'b0);

    // Memory wait beats branch and load-use
    step("mw_over_br",   0, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 1, 1, 0, E_FRZ);
    step("mw_rel_idle",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, E_RUN);
    idle("mw2_after", 1'b0);

    // Timeout: 16 frozen cycles, then sticky error ignoring inputs until reset
    idle("reset_to", 1'b1);
    for (int i = 1; i <= 16; i++)
      step($sformatf("to_frz%0d", i), 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, E_FRZ);
    step("to_err1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, E_ERR);
    step("to_err_rdy",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, E_ERR);
    step("to_err_br",    0, 5'd4, 1, 5'd0, 0, 5'd4, 1, 1, 1, 0, 1, E_ERR);
    idle("to_rst", 1'b1);
    expect_counts(0, 0);
    idle("to_after_rst", 1'b0);
    idle("to_run", 1'b0);

    stim_done = 1'b1;
  end

  initial begin
    int unsigned budget;
    budget = 0;
    while (!(stim_done && q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (budget >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: scoreboard not empty, %0d items left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: max consecutive MEM_WAIT cycles before timeout (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr  in  5 each  ID-stage source register addresses.
REQ-005 SHALL have ports id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 SHALL have port ex_rd_addr  in  5  EX-stage destination register.
REQ-007 SHALL have port ex_reg_wr_en  in  1  EX instruction writes the register file.
REQ-008 SHALL have port ex_mem_rd  in  1  EX instruction is a load.
REQ-009 SHALL have port ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-010 SHALL have ports mem_req  in  1  MEM-stage data access valid; mem_ready  in  1  data memory completes this cycle.
REQ-011 SHALL have ports pc_wr_en, if_id_wr_en  out  1 each  PC / IF-ID register update enables.
REQ-012 SHALL have ports id_ex_bubble, if_id_flush  out  1 each  insert NOP into ID-EX / clear IF-ID.
REQ-013 SHALL have port pipe_freeze  out  1  hold ID-EX, EX-MEM, MEM-WB registers.
REQ-014 SHALL have port mem_timeout  out  1  sticky timeout error flag.
REQ-015 SHALL have ports stall_cycles, flush_events  out  32 each  performance counters.

Function
REQ-016 SHALL implement states RUN, LOAD_STALL, MEM_WAIT, ERROR; outputs combinational from state and inputs.
REQ-017 SHALL define load_use = ex_mem_rd & ex_reg_wr_en & (ex_rd_addr != 0) & ((id_rs1_used & rs1 == ex_rd_addr) | (id_rs2_used & rs2 == ex_rd_addr)).
REQ-018 SHALL, in RUN/LOAD_STALL with mem_req & !mem_ready: pipe_freeze=1, pc_wr_en=0, if_id_wr_en=0, bubble=0, flush=0; next MEM_WAIT; wait counter cleared to 1.
REQ-019 SHALL, in RUN otherwise with ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_wr_en=1, if_id_wr_en=1; stay RUN; load_use ignored.
REQ-020 SHALL, in RUN otherwise with load_use: pc_wr_en=0, if_id_wr_en=0, id_ex_bubble=1; next LOAD_STALL.
REQ-021 SHALL, in RUN with none of the above: pc_wr_en=1, if_id_wr_en=1, all others 0.
REQ-022 SHALL, in LOAD_STALL, suppress load_use detection, apply REQ-018/019/021 rules, return to RUN (exactly one bubble per load-use).
REQ-023 SHALL, in MEM_WAIT, hold REQ-018 outputs; mem_ready -> RUN next cycle; else counter increments; counter == MEM_WAIT_MAX and !mem_ready -> ERROR.
REQ-024 SHALL, in ERROR, assert mem_timeout=1, pipe_freeze=1, pc_wr_en=0, if_id_wr_en=0 until reset; ignore all inputs.
REQ-025 SHALL give priority: mem wait > branch flush > load-use.

Reset
REQ-026 SHALL, on rst high at a clk edge, enter RUN, clear wait counter, mem_timeout=0, both perf counters 0; rst overrides all states including MEM_WAIT and ERROR.
REQ-027 SHALL drive, during reset cycle and first cycle after, RUN outputs per REQ-021.

Configuration
REQ-028 SHALL compile perf counters only when HAZARD_PERF_CNT_EN is defined: stall_cycles +1 each cycle pc_wr_en=0, flush_events +1 each cycle if_id_flush=1, both saturate at 32'hFFFF_FFFF.
REQ-029 SHALL, without HAZARD_PERF_CNT_EN, keep both ports and tie them to 0.

Verification
REQ-030 SHALL cover: ex_mem_rd=1, ex_reg_wr_en=1, ex_rd=5, id_rs1=5, used=1 -> one cycle pc_wr_en=0, bubble=1, then RUN outputs.
REQ-031 SHALL cover: same as REQ-030 but ex_rd=0 or id_rs1_used=0 -> no stall.
REQ-032 SHALL cover: load_use and ex_branch_taken same cycle -> flush=1, bubble=1, pc_wr_en=1, no LOAD_STALL.
REQ-033 SHALL cover: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 for 3 cycles, 0 after; with counters enabled stall_cycles=3.
REQ-034 SHALL cover: mem_ready held 0 with MEM_WAIT_MAX=15 -> mem_timeout=1 after 16th frozen cycle, sticky; rst=1 -> mem_timeout=0, RUN.
